// File: rtl/dmux_dispatch_pkg.sv
// dmux_dispatch_pkg: shared constants, lane slot state and the wrap-around lane search
package dmux_dispatch_pkg;
   localparam int NUM_LANES = 8;
   localparam int LANE_IDX_W = 3;
   localparam logic MODE_RR = 1'b0;
   localparam logic MODE_DIRECTED = 1'b1;
   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
   // Returns {found, lane}: first enabled lane at or after ptr, wrapping 7 -> 0
   function automatic logic [LANE_IDX_W:0] next_en_lane(input logic [NUM_LANES-1:0] en,
                                                        input logic [LANE_IDX_W-1:0] ptr);
      logic [LANE_IDX_W:0] r;
      logic [LANE_IDX_W-1:0] idx;
      r = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         idx = ptr + LANE_IDX_W'(k);
         if (en[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction
endpackage

// File: rtl/dispatch_lane_slot.sv
// dispatch_lane_slot: one-entry holding register for a lane with load, drain and flush
module dispatch_lane_slot
   import dmux_dispatch_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] din,
   output logic             valid,
   output logic [WIDTH-1:0] dout
);
   slot_state_e state_d, state_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      state_d = state_q;
      data_d = data_q;
      if (flush) state_d = SLOT_EMPTY;
      else if (load) begin
         state_d = SLOT_FULL;
         data_d = din;
      end else if (state_q == SLOT_FULL && drain) state_d = SLOT_EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SLOT_EMPTY;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
      end
   end

   assign valid = (state_q == SLOT_FULL);
   assign dout = data_q;
endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// dmux_dispatch_ctrl: spreads one valid/ready stream over 8 lanes, round-robin or directed,
// with a saturating count of directed items sent to disabled lanes.
module dmux_dispatch_ctrl
   import dmux_dispatch_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DROP_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [LANE_IDX_W-1:0]      in_sel,
   input  logic                       cfg_mode,
   input  logic [NUM_LANES-1:0]       cfg_lane_en,
   input  logic                       flush,
   output logic [NUM_LANES-1:0]       out_valid,
   input  logic [NUM_LANES-1:0]       out_ready,
   output logic [NUM_LANES*WIDTH-1:0] out_data,
   output logic [LANE_IDX_W-1:0]      rr_ptr,
   output logic [DROP_W-1:0]          drop_count
);
   logic [NUM_LANES-1:0] free, load;
   logic [LANE_IDX_W:0] srch;
   logic [LANE_IDX_W-1:0] tgt, rr_ptr_d, rr_ptr_q;
   logic [DROP_W-1:0] drop_d, drop_q;
   logic directed, tgt_en, acc;

   // Strict round-robin order: a busy target stalls input rather than skipping ahead
   always_comb begin
      free = ~out_valid | out_ready;
      directed = (cfg_mode == MODE_DIRECTED);
      srch = next_en_lane(cfg_lane_en, rr_ptr_q);
      tgt = directed ? in_sel : srch[LANE_IDX_W-1:0];
      tgt_en = cfg_lane_en[tgt];
      in_ready = ~flush & (directed ? (~tgt_en | free[tgt]) : (srch[LANE_IDX_W] & free[tgt]));
      acc = in_valid & in_ready;
      load = (acc & tgt_en) ? NUM_LANES'(1) << tgt : '0;
      rr_ptr_d = flush ? '0 : (acc & ~directed) ? tgt + LANE_IDX_W'(1) : rr_ptr_q;
      drop_d = (acc & ~tgt_en & ~&drop_q) ? drop_q + DROP_W'(1) : drop_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         drop_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         drop_q <= drop_d;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dispatch_lane_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .reset (reset),
         .flush (flush),
         .load  (load[i]),
         .drain (out_ready[i]),
         .din   (in_data),
         .valid (out_valid[i]),
         .dout  (out_data[i*WIDTH +: WIDTH])
      );
   end

   assign rr_ptr = rr_ptr_q;
   assign drop_count = drop_q;
endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb_dmux_dispatch_ctrl: directed scenarios plus random traffic, checked every cycle
// against a lane-array model of the dispatcher.
module tb_dmux_dispatch_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [7:0] in_data = '0;
   logic [2:0] in_sel = '0;
   logic cfg_mode = 1'b0;
   logic [7:0] cfg_lane_en = '0;
   logic flush = 1'b0;
   logic [7:0] out_valid;
   logic [7:0] out_ready = '0;
   logic [63:0] out_data;
   logic [2:0] rr_ptr;
   logic [7:0] drop_count;

   int n_pass = 0;
   int n_total = 0;

   bit mv[8];
   logic [7:0] md[8];
   int mptr = 0;
   int mdrop = 0;

   always #5 clk = ~clk;

   dmux_dispatch_ctrl #(.WIDTH(8), .DROP_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .cfg_mode(cfg_mode), .cfg_lane_en(cfg_lane_en), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .rr_ptr(rr_ptr),
      .drop_count(drop_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mv[i] = 0;
      mptr = 0;
      mdrop = 0;
   endtask

   task automatic model_eval(output bit rdy, output int t);
      bit found;
      found = 0;
      t = 0;
      if (cfg_mode) begin
         t = in_sel;
         rdy = !cfg_lane_en[t] || !mv[t] || out_ready[t];
      end else begin
         for (int k = 0; k < 8; k++)
            if (!found && cfg_lane_en[(mptr + k) % 8]) begin
               t = (mptr + k) % 8;
               found = 1;
            end
         rdy = found && (!mv[t] || out_ready[t]);
      end
      if (flush) rdy = 0;
   endtask

   task automatic model_commit(input bit rdy, input int t);
      if (flush) begin
         for (int i = 0; i < 8; i++) mv[i] = 0;
         mptr = 0;
      end else begin
         for (int i = 0; i < 8; i++) if (mv[i] && out_ready[i]) mv[i] = 0;
         if (in_valid && rdy) begin
            if (cfg_lane_en[t]) begin
               mv[t] = 1;
               md[t] = in_data;
            end else if (mdrop < 255) mdrop++;
            if (!cfg_mode) mptr = (t + 1) % 8;
         end
      end
   endtask

   // Called at the falling edge with inputs already applied; returns at the next falling edge
   task automatic cyc();
      bit rdy;
      int t;
      logic [7:0] ev;
      #1;
      model_eval(rdy, t);
      for (int i = 0; i < 8; i++) ev[i] = mv[i];
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("out_valid", 64'(out_valid), 64'(ev));
      for (int i = 0; i < 8; i++)
         if (mv[i]) chk($sformatf("lane%0d_data", i), 64'(out_data[i*8 +: 8]), 64'(md[i]));
      chk("rr_ptr", 64'(rr_ptr), 64'(mptr));
      chk("drop_count", 64'(drop_count), 64'(mdrop));
      @(posedge clk);
      model_commit(rdy, t);
      @(negedge clk);
   endtask

   task automatic do_flush();
      in_valid = 0;
      flush = 1;
      cyc();
      flush = 0;
   endtask

   initial begin
      logic [2:0] p0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_rr_ptr", 64'(rr_ptr), 64'h0);
      chk("rst_drop", 64'(drop_count), 64'h0);
      @(negedge clk);
      reset = 0;

      // back-to-back round-robin, all lanes ready
      cfg_mode = 0; cfg_lane_en = 8'hFF; out_ready = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1; in_data = 8'(8'h10 + k);
         cyc();
      end
      in_valid = 0;
      chk("s1_rr_ptr", 64'(rr_ptr), 64'h2);
      chk("s1_lane1_data", 64'(out_data[15:8]), 64'h19);
      chk("s1_lane0_data", 64'(out_data[7:0]), 64'h18);
      cyc();

      // sparse enable mask: lanes 2,5,7,2
      do_flush();
      cfg_lane_en = 8'b1010_0100;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1; in_data = 8'(8'h40 + k);
         cyc();
         chk("s2_rr_ptr", 64'(rr_ptr), (k == 0) ? 64'h3 : (k == 1) ? 64'h6 : (k == 2) ? 64'h0 : 64'h3);
      end
      in_valid = 0;
      cyc();

      // strict order stall on lane 3
      do_flush();
      cfg_lane_en = 8'hFF; out_ready = 8'b1111_0111;
      for (int k = 0; k < 11; k++) begin
         in_valid = 1; in_data = 8'(8'h60 + k);
         cyc();
      end
      chk("s3_ptr_at_3", 64'(rr_ptr), 64'h3);
      in_data = 8'hA5;
      for (int k = 0; k < 3; k++) begin
         #1 chk("s3_stalled", 64'(in_ready), 64'h0);
         cyc();
      end
      out_ready = 8'hFF;
      #1 chk("s3_unstall", 64'(in_ready), 64'h1);
      cyc();
      in_valid = 0; out_ready = 8'h00;
      chk("s3_lane3_valid", 64'(out_valid[3]), 64'h1);
      chk("s3_lane3_data", 64'(out_data[31:24]), 64'hA5);
      cyc();

      // directed to a disabled lane: drops saturate
      do_flush();
      out_ready = 8'hFF; cfg_mode = 1; cfg_lane_en = 8'hBF; in_sel = 3'd6;
      p0 = rr_ptr;
      for (int k = 0; k < 300; k++) begin
         in_valid = 1; in_data = 8'($urandom);
         cyc();
      end
      in_valid = 0;
      chk("s4_drop_sat", 64'(drop_count), 64'd255);
      chk("s4_ptr_same", 64'(rr_ptr), 64'(p0));
      chk("s4_no_valid", 64'(out_valid), 64'h0);

      // flush with lanes 0 and 4 stalled
      cfg_mode = 0; cfg_lane_en = 8'h11; out_ready = 8'h00;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1; in_data = 8'(8'h70 + k);
         cyc();
      end
      chk("s5_full", 64'(out_valid), 64'h11);
      in_valid = 1; flush = 1;
      #1 chk("s5_flush_ready", 64'(in_ready), 64'h0);
      cyc();
      flush = 0; in_valid = 0;
      chk("s5_valid_clr", 64'(out_valid), 64'h0);
      chk("s5_ptr_clr", 64'(rr_ptr), 64'h0);
      chk("s5_drop_held", 64'(drop_count), 64'd255);

      // async reset between edges with three lanes full
      cfg_lane_en = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_data = 8'(8'h80 + k);
         cyc();
      end
      in_valid = 0;
      #3 reset = 1;
      #1;
      chk("s6_async_valid", 64'(out_valid), 64'h0);
      chk("s6_async_ptr", 64'(rr_ptr), 64'h0);
      chk("s6_async_drop", 64'(drop_count), 64'h0);
      model_reset();
      @(negedge clk);
      reset = 0;
      in_valid = 1; in_data = 8'hC3; out_ready = 8'h00;
      cyc();
      in_valid = 0;
      chk("s6_resume_lane0", 64'(out_valid), 64'h01);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = 8'($urandom);
         in_sel = 3'($urandom);
         if ($urandom_range(0, 15) == 0) cfg_mode = ~cfg_mode;
         if ($urandom_range(0, 15) == 0) cfg_lane_en = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         out_ready = 8'($urandom);
         flush = ($urandom_range(0, 39) == 0);
         cyc();
      end
      flush = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
